// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and sizing for the serial pattern detector.
package seq_pattern_detector_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam int FILL_W      = $clog2(MAX_PAT_LEN + 1);

    typedef enum logic {
        FILL,
        HUNT
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, selectable
// overlapping matches and a saturating match counter.
module seq_pattern_detector
    import seq_pattern_detector_pkg::*;
#(
    parameter int                 PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PAT_RST = 3'b101,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               det,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               armed
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_LEN);

    state_t             state_r, state_nx;
    logic [PAT_LEN-1:0] pat_r, hist_r, hist_nx, hist_sh;
    logic [FILL_W-1:0]  fill_r, fill_nx, fill_inc;
    logic               accept, match;

    // A load in the same cycle as a valid bit discards the bit.
    assign accept   = in_valid && !pat_load;
    assign hist_sh  = {hist_r[PAT_LEN-2:0], in};
    assign fill_inc = (fill_r == FULL) ? FULL : fill_r + 1'b1;
    assign match    = accept && (hist_sh == pat_r) && (fill_inc == FULL);

    always_comb begin
        state_nx = state_r;
        fill_nx  = fill_r;
        hist_nx  = hist_r;
        if (pat_load) begin
            state_nx = FILL;
            fill_nx  = '0;
            hist_nx  = '0;
        end else if (accept) begin
            hist_nx = hist_sh;
            // Non-overlapping: stale history must be fully refilled first.
            if (match && !overlap) begin
                state_nx = FILL;
                fill_nx  = '0;
            end else begin
                fill_nx  = fill_inc;
                state_nx = (fill_inc == FULL) ? HUNT : FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= FILL;
            pat_r   <= PAT_RST;
            hist_r  <= '0;
            fill_r  <= '0;
            det     <= 1'b0;
        end else begin
            state_r <= state_nx;
            hist_r  <= hist_nx;
            fill_r  <= fill_nx;
            det     <= match;
            if (pat_load)
                pat_r <= pat;
        end
    end

    assign armed = (state_r == HUNT);

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

endmodule
